// File: rtl/relogio_display.sv
// relogio_display: samples the clock/stopwatch time fields once per frame,
// converts them to BCD with a subtract-10 engine and scans them onto an
// 8-digit common-anode 7-segment display (all outputs active-low).
// Optional: define LEADING_ZERO_BLANK_EN to blank a zero hours-tens digit.
module relogio_display #(
  parameter int unsigned PRESCALE = 1000
) (
  input  logic       clk,
  input  logic       res,
  input  logic [4:0] hora,
  input  logic [5:0] minutos,
  input  logic [5:0] segundos,
  input  logic [6:0] centsegundos,
  input  logic       nrc,
  output logic [7:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame
);

  localparam int unsigned CNT_W = 16;
  localparam int unsigned DIG_W = 4;
  localparam int unsigned BUF_W = 8 * DIG_W;
  localparam int unsigned VAL_W = 7;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PRESCALE - 1);
  localparam logic [DIG_W-1:0] DASH    = 4'hF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } conv_state_e;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic             tick_c, snap_tick_c, swap_tick_c;

  logic [4:0]       snap_hr_q, snap_hr_d;
  logic [5:0]       snap_min_q, snap_min_d;
  logic [5:0]       snap_sec_q, snap_sec_d;
  logic [6:0]       snap_cs_q, snap_cs_d;
  logic             snap_nrc_q, snap_nrc_d;

  conv_state_e      state_q, state_d;
  logic [1:0]       fld_q, fld_d;
  logic [VAL_W-1:0] val_q, val_d;
  logic [DIG_W-1:0] tens_q, tens_d;
  logic [BUF_W-1:0] wbuf_q, wbuf_d;
  logic [BUF_W-1:0] dbuf_q, dbuf_d;
  logic             dnrc_q, dnrc_d;

  logic [VAL_W-1:0] fld_val_c, fld_max_c, nxt_val_c;
  logic [DIG_W-1:0] code_c;

  logic [7:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;
  logic             frame_q, frame_d;

  function automatic logic [6:0] seg_decode(input logic [DIG_W-1:0] code);
    logic [6:0] s;
    case (code)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      DASH:    s = 7'h3F;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  // Digit-slot prescaler and frame-phase ticks
  always_comb begin
    tick_c      = (cnt_q == CNT_MAX);
    cnt_d       = tick_c ? '0 : cnt_q + CNT_W'(1);
    snap_tick_c = tick_c && (idx_q == 3'd6);
    swap_tick_c = tick_c && (idx_q == 3'd7);
  end

  // Snapshot value, legal maximum and successor of the field being converted
  always_comb begin
    fld_val_c = '0;
    fld_max_c = '0;
    nxt_val_c = '0;
    case (fld_q)
      2'd0: begin
        fld_val_c = snap_cs_q;
        fld_max_c = 7'd99;
        nxt_val_c = VAL_W'(snap_sec_q);
      end
      2'd1: begin
        fld_val_c = VAL_W'(snap_sec_q);
        fld_max_c = 7'd59;
        nxt_val_c = VAL_W'(snap_min_q);
      end
      2'd2: begin
        fld_val_c = VAL_W'(snap_min_q);
        fld_max_c = 7'd59;
        nxt_val_c = VAL_W'(snap_hr_q);
      end
      default: begin
        fld_val_c = VAL_W'(snap_hr_q);
        fld_max_c = 7'd23;
        nxt_val_c = '0;
      end
    endcase
  end

  // Snapshot capture and IDLE/CONV/DONE subtract-10 converter
  always_comb begin
    state_d    = state_q;
    fld_d      = fld_q;
    val_d      = val_q;
    tens_d     = tens_q;
    wbuf_d     = wbuf_q;
    snap_hr_d  = snap_hr_q;
    snap_min_d = snap_min_q;
    snap_sec_d = snap_sec_q;
    snap_cs_d  = snap_cs_q;
    snap_nrc_d = snap_nrc_q;
    if (swap_tick_c) begin
      state_d = IDLE;
    end else if (snap_tick_c) begin
      snap_hr_d  = hora;
      snap_min_d = minutos;
      snap_sec_d = segundos;
      snap_cs_d  = centsegundos;
      snap_nrc_d = nrc;
      state_d    = CONV;
      fld_d      = 2'd0;
      val_d      = centsegundos;
      tens_d     = '0;
    end else if (state_q == CONV) begin
      if (val_q >= 7'd10 && fld_val_c <= fld_max_c) begin
        val_d  = val_q - 7'd10;
        tens_d = tens_q + 4'd1;
      end else begin
        if (fld_val_c > fld_max_c) begin
          wbuf_d[{fld_q, 3'b000} +: 8] = {DASH, DASH};
        end else begin
          wbuf_d[{fld_q, 3'b000} +: 8] = {tens_q, val_q[DIG_W-1:0]};
        end
        fld_d  = fld_q + 2'd1;
        val_d  = nxt_val_c;
        tens_d = '0;
        if (fld_q == 2'd3) begin
          state_d = DONE;
        end
      end
    end
  end

  // Digit scan, buffer swap and registered display outputs
  always_comb begin
    idx_d   = idx_q;
    dbuf_d  = dbuf_q;
    dnrc_d  = dnrc_q;
    an_d    = an_q;
    seg_d   = seg_q;
    dp_d    = dp_q;
    frame_d = 1'b0;
    code_c  = '0;
    if (tick_c) begin
      idx_d = idx_q + 3'd1;
      if (swap_tick_c) begin
        dbuf_d  = wbuf_q;
        dnrc_d  = snap_nrc_q;
        frame_d = 1'b1;
      end
      code_c = dbuf_d[{idx_d, 2'b00} +: DIG_W];
      an_d   = ~(8'd1 << idx_d);
      seg_d  = seg_decode(code_c);
`ifdef LEADING_ZERO_BLANK_EN
      if (idx_d == 3'd7 && code_c == 4'd0) begin
        seg_d = 7'h7F;
      end
`endif
      case (idx_d)
        3'd2, 3'd4, 3'd6: dp_d = 1'b0;
        3'd0:             dp_d = dnrc_d;
        default:          dp_d = 1'b1;
      endcase
    end
  end

  // State registers
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      cnt_q      <= '0;
      idx_q      <= 3'd6;
      snap_hr_q  <= '0;
      snap_min_q <= '0;
      snap_sec_q <= '0;
      snap_cs_q  <= '0;
      snap_nrc_q <= 1'b0;
      state_q    <= IDLE;
      fld_q      <= '0;
      val_q      <= '0;
      tens_q     <= '0;
      wbuf_q     <= '0;
      dbuf_q     <= '0;
      dnrc_q     <= 1'b0;
      an_q       <= 8'hFF;
      seg_q      <= 7'h7F;
      dp_q       <= 1'b1;
      frame_q    <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      snap_hr_q  <= snap_hr_d;
      snap_min_q <= snap_min_d;
      snap_sec_q <= snap_sec_d;
      snap_cs_q  <= snap_cs_d;
      snap_nrc_q <= snap_nrc_d;
      state_q    <= state_d;
      fld_q      <= fld_d;
      val_q      <= val_d;
      tens_q     <= tens_d;
      wbuf_q     <= wbuf_d;
      dbuf_q     <= dbuf_d;
      dnrc_q     <= dnrc_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      frame_q    <= frame_d;
    end
  end

  assign an    = an_q;
  assign seg   = seg_q;
  assign dp    = dp_q;
  assign frame = frame_q;

endmodule
